hangman_engine: RTL and testbench

// Parametrised game engine for the blind-hangman chip: next generation of the hangy

---
 rtl/hangman_engine.sv | 166 ++++++++++++++++
 tb/tb_hangman_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hangman_engine.sv
// Hangman game engine: word table, LFSR or forced word pick, guess handshake,
// parallel position match and a used-letter bitmap so that repeated guesses cost nothing.
module hangman_engine #(
    parameter int WORD_LEN  = 5,
    parameter int CHAR_W    = 5,
    parameter int NUM_WORDS = 4,
    parameter int MAX_TRIES = 7,
    parameter logic [NUM_WORDS*WORD_LEN*CHAR_W-1:0] WORD_ROM = '0,
    parameter logic [7:0] LFSR_SEED = 8'h01,
    localparam int IDX_W = $clog2(NUM_WORDS),
    localparam int TRY_W = $clog2(MAX_TRIES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic                guess_valid,
    input  logic [CHAR_W-1:0]   guess_char,
    output logic                guess_ready,
    output logic [WORD_LEN-1:0] guessed_mask,
    output logic [TRY_W-1:0]    tries_used,
    output logic [IDX_W-1:0]    word_idx,
    output logic                hit,
    output logic                miss,
    output logic                repeat_g,
    output logic                win,
    output logic                lose
);

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_GUESS, S_CHECK, S_WIN, S_LOSE
    } state_t;

    localparam int NUM_CHARS = 2 ** CHAR_W;
    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

    state_t                 state_q, state_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [IDX_W-1:0]       pick_q, pick_d;
    logic [IDX_W-1:0]       word_idx_q, word_idx_d;
    logic [CHAR_W-1:0]      char_q, char_d;
    logic [NUM_CHARS-1:0]   used_q, used_d;
    logic [WORD_LEN-1:0]    mask_q, mask_d;
    logic [TRY_W-1:0]       tries_q, tries_d;
    logic                   ready_q, ready_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic                   repeat_q, repeat_d;
    logic                   win_q, win_d;
    logic                   lose_q, lose_d;
    logic [WORD_LEN-1:0]    match;

    always_comb begin
        match = '0;
        for (int p = 0; p < WORD_LEN; p++) begin
            match[p] = (WORD_ROM[(int'(word_idx_q) * WORD_LEN + p) * CHAR_W +: CHAR_W] == char_q);
        end
    end

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running so the pick depends on start timing
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d    = state_q;
        pick_d     = pick_q;
        word_idx_d = word_idx_q;
        char_d     = char_q;
        used_d     = used_q;
        mask_d     = mask_q;
        tries_d    = tries_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        repeat_d   = 1'b0;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    pick_d  = sel_valid ? sel_idx : lfsr_q[IDX_W-1:0];
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                word_idx_d = pick_q;
                mask_d     = '0;
                tries_d    = '0;
                used_d     = '0;
                state_d    = S_GUESS;
            end
            S_GUESS: begin
                if (guess_valid && ready_q) begin
                    char_d  = guess_char;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (used_q[char_q]) begin
                    repeat_d = 1'b1;
                    state_d  = S_GUESS;
                end else begin
                    used_d[char_q] = 1'b1;
                    if (|match) begin
                        mask_d = mask_q | match;
                        hit_d  = 1'b1;
                    end else begin
                        if (tries_q != TRIES_MAX) tries_d = tries_q + TRY_W'(1);
                        miss_d = 1'b1;
                    end
                    if (&mask_d)                  state_d = S_WIN;
                    else if (tries_d == TRIES_MAX) state_d = S_LOSE;
                    else                          state_d = S_GUESS;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_GUESS);
        win_d   = (state_d == S_WIN);
        lose_d  = (state_d == S_LOSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            pick_q     <= '0;
            word_idx_q <= '0;
            char_q     <= '0;
            used_q     <= '0;
            mask_q     <= '0;
            tries_q    <= '0;
            ready_q    <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            repeat_q   <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            pick_q     <= pick_d;
            word_idx_q <= word_idx_d;
            char_q     <= char_d;
            used_q     <= used_d;
            mask_q     <= mask_d;
            tries_q    <= tries_d;
            ready_q    <= ready_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            repeat_q   <= repeat_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    assign guess_ready  = ready_q;
    assign guessed_mask = mask_q;
    assign tries_used   = tries_q;
    assign word_idx     = word_idx_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign repeat_g     = repeat_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_hangman_engine.sv
// Directed bench for hangman_engine: word0 = 8,5,12,12,15, hand-computed expectations.
module tb_hangman_engine;

    localparam logic [99:0] ROM = {
        {5'd3,  5'd3,  5'd3,  5'd3,  5'd3},
        {5'd22, 5'd21, 5'd20, 5'd19, 5'd18},
        {5'd6,  5'd4,  5'd3,  5'd2,  5'd1},
        {5'd15, 5'd12, 5'd12, 5'd5,  5'd8}
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_idx = 2'd0;
    logic       guess_valid = 1'b0;
    logic [4:0] guess_char = 5'd0;
    logic       guess_ready;
    logic [4:0] guessed_mask;
    logic [2:0] tries_used;
    logic [1:0] word_idx;
    logic       hit, miss, repeat_g, win, lose;

    logic [7:0] m_lfsr;
    logic [1:0] exp_idx;
    int         n_chk = 0;
    int         n_err = 0;

    hangman_engine #(
        .WORD_LEN(5), .CHAR_W(5), .NUM_WORDS(4), .MAX_TRIES(7),
        .WORD_ROM(ROM), .LFSR_SEED(8'h01)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .guess_valid(guess_valid), .guess_char(guess_char), .guess_ready(guess_ready),
        .guessed_mask(guessed_mask), .tries_used(tries_used), .word_idx(word_idx),
        .hit(hit), .miss(miss), .repeat_g(repeat_g), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'h01;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic new_game(input logic sv, input logic [1:0] idx);
        start = 1'b1; sel_valid = sv; sel_idx = idx;
        @(negedge clk);
        start = 1'b0; sel_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_guess(input logic [4:0] c);
        for (int i = 0; i < 20 && !guess_ready; i++) @(negedge clk);
        chk("ready_before_guess", int'(guess_ready), 1);
        guess_valid = 1'b1; guess_char = c;
        @(negedge clk);
        guess_valid = 1'b0;
        chk("ready_low_in_check", int'(guess_ready), 0);
        @(negedge clk);
    endtask

    task automatic chk_pulses(input string tag, input logic h, input logic m, input logic r);
        chk(tag, int'({hit, miss, repeat_g}), int'({h, m, r}));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", int'(guess_ready), 0);
        chk("reset_mask", int'(guessed_mask), 0);

        // reset mid-GUESS after a hit
        new_game(1'b1, 2'd0);
        do_guess(5'd12);
        chk("t1_hit_mask", int'(guessed_mask), 5'b01100);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_mask", int'(guessed_mask), 0);
        chk("t1_rst_tries", int'(tries_used), 0);
        chk("t1_rst_ready", int'(guess_ready), 0);
        chk("t1_rst_hit", int'(hit), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_idle_ready", int'(guess_ready), 0);

        // first hit, repeat, miss, repeat of a miss
        new_game(1'b1, 2'd0);
        chk("t2_ready", int'(guess_ready), 1);
        chk("t2_idx", int'(word_idx), 0);
        do_guess(5'd12);
        chk("t2_mask", int'(guessed_mask), 5'b01100);
        chk_pulses("t2_pulse", 1'b1, 1'b0, 1'b0);
        chk("t2_tries", int'(tries_used), 0);
        @(negedge clk);
        chk_pulses("t2_pulse_gone", 1'b0, 1'b0, 1'b0);
        do_guess(5'd12);
        chk_pulses("t3_rep12", 1'b0, 1'b0, 1'b1);
        chk("t3_rep12_mask", int'(guessed_mask), 5'b01100);
        do_guess(5'd26);
        chk_pulses("t3_miss26", 1'b0, 1'b1, 1'b0);
        chk("t3_miss26_tries", int'(tries_used), 1);
        do_guess(5'd26);
        chk_pulses("t3_rep26", 1'b0, 1'b0, 1'b1);
        chk("t3_rep26_tries", int'(tries_used), 1);

        // finish the word
        do_guess(5'd8);
        chk("t4_mask8", int'(guessed_mask), 5'b01101);
        do_guess(5'd5);
        chk("t4_mask5", int'(guessed_mask), 5'b01111);
        do_guess(5'd12);
        chk_pulses("t4_rep12", 1'b0, 1'b0, 1'b1);
        do_guess(5'd15);
        chk("t4_mask15", int'(guessed_mask), 5'b11111);
        chk("t4_win", int'(win), 1);
        chk("t4_ready", int'(guess_ready), 0);
        chk("t4_tries", int'(tries_used), 1);
        chk_pulses("t4_hit15", 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_win_hold", int'(win), 1);
        new_game(1'b1, 2'd0);
        chk("t4_restart_win", int'(win), 0);
        chk("t4_restart_mask", int'(guessed_mask), 0);
        chk("t4_restart_tries", int'(tries_used), 0);

        // seven misses -> lose, then guesses ignored
        do_guess(5'd1); do_guess(5'd2); do_guess(5'd3);
        do_guess(5'd4); do_guess(5'd6); do_guess(5'd7);
        chk("t5_tries6", int'(tries_used), 6);
        chk("t5_not_lost", int'(lose), 0);
        do_guess(5'd9);
        chk("t5_tries7", int'(tries_used), 7);
        chk("t5_lose", int'(lose), 1);
        chk("t5_ready", int'(guess_ready), 0);
        guess_valid = 1'b1; guess_char = 5'd8;
        repeat (4) @(negedge clk);
        guess_valid = 1'b0;
        chk("t5_ign_mask", int'(guessed_mask), 0);
        chk("t5_ign_tries", int'(tries_used), 7);
        chk("t5_ign_lose", int'(lose), 1);
        chk_pulses("t5_ign_pulse", 1'b0, 1'b0, 1'b0);

        // forced index to a different word
        new_game(1'b1, 2'd2);
        chk("t5_idx2", int'(word_idx), 2);
        chk("t5_lose_clr", int'(lose), 0);
        do_guess(5'd20);
        chk("t5_w2_mask", int'(guessed_mask), 5'b00100);

        // LFSR pick: seed 01 -> 02,04,08,11 after 4 edges, so index 1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        new_game(1'b0, 2'd3);
        chk("t6_idx_hand", int'(word_idx), 1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (13) @(negedge clk);
        exp_idx = m_lfsr[1:0];
        new_game(1'b0, 2'd0);
        chk("t6_idx_model", int'(word_idx), int'(exp_idx));

        repeat (9) @(negedge clk);
        exp_idx = m_lfsr[1:0];
        new_game(1'b0, 2'd0);
        chk("t6_idx_model2", int'(word_idx), int'(exp_idx));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
